hls8x2_4_sdiv_seq: RTL and testbench
====================================

// Module: hls8x2_4_sdiv_seq
// PURPOSE
//  Sequential signed 16-bit divider. It is the inverse operator of the
//  truncating 16x16 signed multiplier core. Given dividend a and divisor b it
//  returns quotient and remainder with C semantics: the quotient truncates
//  toward zero and the remainder takes the sign of the dividend.
//  It sits beside the multiplier cores in the HLS8x2_4 datapath and is used
//  for the scale/normalise step. One operation is in flight at a time.
// PARAMETERS
//  W         16  operand, quotient and remainder width, in bits
//  ID        1   instance ID for tool bookkeeping; no functional effect
// PORTS
//  ap_clk     in   1  clock; all logic is on the rising edge
//  ap_rst     in   1  synchronous, active-high reset
//  in_valid   in   1  din0 and din1 are valid
//  in_ready   out  1  the block can accept an operation
//  din0       in   W  dividend, signed
//  din1       in   W  divisor, signed
//  out_valid  out  1  quot, rem and the flags are valid
//  out_ready  in   1  the consumer takes the result
//  quot       out  W  quotient, signed, truncated toward zero
//  rem        out  W  remainder, signed, same sign as din0
//  dbz        out  1  divide-by-zero occurred
//  ovf        out  1  the -2^(W-1) / -1 case occurred
// BEHAVIOUR
//  Reset values: state=IDLE, in_ready=1, out_valid=0, quot=0, rem=0, dbz=0, ovf=0.
//  FSM states: IDLE, CALC, FIX, DONE.
//  - IDLE: in_ready=1. On in_valid at edge T, capture the operands.
//    Store |din0| and |din1| as W+1-bit magnitudes and latch both signs.
//    Clear the step counter. Go to CALC.
//  - CALC: one restoring step per cycle, edges T+1 to T+16 (W steps).
//    Each step: shift the partial remainder left and bring in the next
//    dividend MSB. Trial-subtract |b|. If the result is >= 0, keep it and
//    set the quotient bit to 1; otherwise set the quotient bit to 0.
//    After step W-1, go to FIX.
//  - FIX, at edge T+17:
//    - Negate the quotient if sign(a) != sign(b).
//    - Negate the remainder if sign(a) = 1.
//    - Register quot, rem, dbz and ovf, set out_valid=1, go to DONE.
//  - DONE: out_valid=1 and all outputs are held stable.
//    On out_ready: clear out_valid and go to IDLE at the next edge.
//  in_ready=1 only in IDLE. There is no accept in DONE, even if out_ready=1.
//  Latency: out_valid is first seen high after edge T+17.
//  Minimum issue interval is 19 cycles.
//  Divide-by-zero (din1=0): same fixed latency, no early exit.
//    quot=16'hFFFF, rem=din0, dbz=1, ovf=0.
//  Overflow (din0=16'h8000, din1=16'hFFFF): quot=16'h8000 (wraps, as the
//    C cast does), rem=0, ovf=1.
//  Width rule: magnitudes use W+1 bits so that |-32768| is representable.
//    Outputs take the low W bits.
//  in_valid while not in IDLE is ignored; the operands are not captured.
//  Result payloads (quot, rem, dbz, ovf) change only at the FIX edge.
//    They keep their last value while the block is in IDLE.
//  ap_rst in any state: at the next edge, return to the reset values.
//    A partial result is never presented.
// STRUCTURE
//  Package hls8x2_4_div_pkg holds:
//    - W_DEF = 16
//    - the state enum {IDLE, CALC, FIX, DONE}
//    - DBZ_QUOT = 16'hFFFF
//    - the function abs_ext(x), which returns |x| as W+1 bits
//  Sub-module hls8x2_4_div_step is combinational, one restoring step:
//    in:  prem[W:0], dbit, dvsr[W:0]
//    out: nprem[W:0], qbit
//  Top level: the FSM, a counter of ceil(log2(W)) bits, and the operand,
//    partial-remainder and quotient registers.
// TESTING
//  1. din0=100, din1=7, accepted at T:
//     quot=14, rem=2, dbz=0, ovf=0; out_valid seen after edge T+17.
//  2. din0=-100, din1=7:
//     quot=16'hFFF2 (-14), rem=16'hFFFE (-2).
//     Also din0=100, din1=-7: quot=-14, rem=2.
//  3. din0=16'h8000, din1=16'hFFFF:
//     quot=16'h8000, rem=0, ovf=1.
//     Also din0=16'h8000, din1=1: quot=16'h8000, rem=0, ovf=0.
//  4. din0=5, din1=0:
//     quot=16'hFFFF, rem=5, dbz=1; latency is still 17 cycles.
//  5. Hold out_ready=0 for 5 cycles after out_valid:
//     quot and rem are stable, in_ready=0, and an in_valid pulse is ignored.
//     Then out_ready=1: in_ready=1 one cycle later.
//  6. Assert ap_rst at edge T+8, during CALC:
//     out_valid=0, in_ready=1, quot=0.
//     Then issue 7/2: quot=3, rem=1.

Source files
------------

// File: rtl/hls8x2_4_div_pkg.sv
// Shared types, constants and helpers for the sequential signed divider.
package hls8x2_4_div_pkg;

   localparam int unsigned W_DEF = 16;

   localparam logic [W_DEF-1:0] DBZ_QUOT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

   // |x| widened by one bit so that |-2^(W-1)| is representable
   function automatic logic [W_DEF:0] abs_ext(input logic [W_DEF-1:0] x);
      logic [W_DEF:0] xe;
      xe = {x[W_DEF-1], x};
      return xe[W_DEF] ? -xe : xe;
   endfunction

endpackage

// File: rtl/hls8x2_4_sdiv_seq_if.sv
// Operand/result handshake bundle of the sequential signed divider.
interface hls8x2_4_sdiv_seq_if
   import hls8x2_4_div_pkg::*;
#(
   parameter int unsigned W = W_DEF
) ();

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] din0;
   logic [W-1:0] din1;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] quot;
   logic [W-1:0] rem;
   logic         dbz;
   logic         ovf;

   modport master (
      output in_valid, din0, din1, out_ready,
      input  in_ready, out_valid, quot, rem, dbz, ovf
   );

   modport slave (
      input  in_valid, din0, din1, out_ready,
      output in_ready, out_valid, quot, rem, dbz, ovf
   );

endinterface

// File: rtl/hls8x2_4_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module hls8x2_4_div_step
   import hls8x2_4_div_pkg::*;
#(
   parameter int unsigned W = W_DEF
) (
   input  logic [W:0] prem_i,
   input  logic       dbit_i,
   input  logic [W:0] dvsr_i,
   output logic [W:0] nprem_o,
   output logic       qbit_o
);

   localparam int unsigned MW = W + 1;

   logic [W:0] shifted_c;

   // Partial remainder stays below |b|, so the shifted value fits in W+1 bits
   always_comb begin
      shifted_c = (prem_i << 1) | MW'(dbit_i);
      qbit_o    = (shifted_c >= dvsr_i);
      nprem_o   = qbit_o ? (shifted_c - dvsr_i) : shifted_c;
   end

endmodule

// File: rtl/hls8x2_4_sdiv_seq.sv
// Sequential signed W-bit divider, C semantics (truncating quotient,
// remainder takes the dividend's sign), one operation in flight.
module hls8x2_4_sdiv_seq
   import hls8x2_4_div_pkg::*;
#(
   parameter int unsigned W  = W_DEF,
   parameter int unsigned ID = 1
) (
   input  logic               ap_clk,
   input  logic               ap_rst,
   hls8x2_4_sdiv_seq_if.slave bus
);

   localparam int unsigned   CW        = $clog2(W);
   localparam int unsigned   MW        = W + 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);
   localparam logic [W-1:0]  MIN_NEG   = {1'b1, {(W-1){1'b0}}};

   // Instance tag only; kept visible for tool bookkeeping
   if (ID == 0) begin : g_id_zero
   end

   div_state_e    state_q;
   logic [CW-1:0] cnt_q;
   logic [W:0]    dq_q;        // dividend magnitude, shifted out as quotient shifts in
   logic [W:0]    dvsr_q;
   logic [W:0]    prem_q;
   logic          a_neg_q;
   logic          q_neg_q;
   logic          dbz_flag_q;
   logic          ovf_flag_q;
   logic          in_ready_q;
   logic          out_valid_q;
   logic [W-1:0]  quot_q;
   logic [W-1:0]  rem_q;
   logic          dbz_q;
   logic          ovf_q;

   logic [W:0]    nprem_c;
   logic          qbit_c;

   hls8x2_4_div_step #(.W(W)) u_step (
      .prem_i  (prem_q),
      .dbit_i  (dq_q[W-1]),
      .dvsr_i  (dvsr_q),
      .nprem_o (nprem_c),
      .qbit_o  (qbit_c)
   );

   // Control FSM with operand, partial-remainder and result registers
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dq_q        <= '0;
         dvsr_q      <= '0;
         prem_q      <= '0;
         a_neg_q     <= 1'b0;
         q_neg_q     <= 1'b0;
         dbz_flag_q  <= 1'b0;
         ovf_flag_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         quot_q      <= '0;
         rem_q       <= '0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  dq_q       <= abs_ext(bus.din0);
                  dvsr_q     <= abs_ext(bus.din1);
                  prem_q     <= '0;
                  cnt_q      <= '0;
                  a_neg_q    <= bus.din0[W-1];
                  q_neg_q    <= bus.din0[W-1] ^ bus.din1[W-1];
                  dbz_flag_q <= (bus.din1 == '0);
                  ovf_flag_q <= (bus.din0 == MIN_NEG) && (bus.din1 == '1);
                  in_ready_q <= 1'b0;
                  state_q    <= CALC;
               end
            end
            CALC: begin
               prem_q <= nprem_c;
               dq_q   <= (dq_q << 1) | MW'(qbit_c);
               cnt_q  <= cnt_q + CW'(1);
               if (cnt_q == LAST_STEP) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               // Divide-by-zero forces all-ones; remainder of |a|/0 is |a|, re-signed to din0
               if (dbz_flag_q) begin
                  quot_q <= W'(DBZ_QUOT);
               end else begin
                  quot_q <= q_neg_q ? -dq_q[W-1:0] : dq_q[W-1:0];
               end
               rem_q       <= a_neg_q ? -prem_q[W-1:0] : prem_q[W-1:0];
               dbz_q       <= dbz_flag_q;
               ovf_q       <= ovf_flag_q;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.quot      = quot_q;
   assign bus.rem       = rem_q;
   assign bus.dbz       = dbz_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_hls8x2_4_sdiv_seq.sv
// Directed bench for the sequential signed divider: vector table plus
// hand-written stall and mid-calculation reset sequences.
module tb_hls8x2_4_sdiv_seq;
   import hls8x2_4_div_pkg::*;

   logic ap_clk = 1'b0;
   logic ap_rst;

   hls8x2_4_sdiv_seq_if #(.W(16)) bus ();

   hls8x2_4_sdiv_seq #(.W(16), .ID(1)) dut (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .bus    (bus)
   );

   always #5 ap_clk = ~ap_clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
      logic        ovf;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs[NV];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Wait (bounded) for in_ready, present one operation, return just after the accept edge
   task automatic start_op(input logic [15:0] a, input logic [15:0] b);
      int n;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(negedge ap_clk);
         n++;
      end
      chk("accept_ready", 16'(bus.in_ready), 16'd1);
      bus.din0     = a;
      bus.din1     = b;
      bus.in_valid = 1'b1;
      @(posedge ap_clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Count edges after the accept edge until out_valid is seen (bounded)
   task automatic wait_result(output int lat);
      lat = 0;
      do begin
         @(posedge ap_clk);
         #1;
         lat++;
      end while (bus.out_valid !== 1'b1 && lat < 40);
   endtask

   task automatic release_result(input string nm);
      bus.out_ready = 1'b1;
      @(posedge ap_clk);
      #1;
      bus.out_ready = 1'b0;
      chk({nm, " out_valid_clr"}, 16'(bus.out_valid), 16'd0);
      chk({nm, " in_ready_back"}, 16'(bus.in_ready), 16'd1);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int    lat;
      string nm;
      nm = $sformatf("v%0d(%h/%h)", idx, v.a, v.b);
      start_op(v.a, v.b);
      wait_result(lat);
      chk({nm, " latency"}, 16'(lat), 16'd17);
      chk({nm, " quot"}, bus.quot, v.q);
      chk({nm, " rem"}, bus.rem, v.r);
      chk({nm, " dbz"}, 16'(bus.dbz), 16'(v.dbz));
      chk({nm, " ovf"}, 16'(bus.ovf), 16'(v.ovf));
      release_result(nm);
   endtask

   initial begin
      int lat;

      vecs[0]  = '{16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 1'b0};
      vecs[1]  = '{16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 1'b0};
      vecs[2]  = '{16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0};
      vecs[3]  = '{16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0};
      vecs[4]  = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1};
      vecs[5]  = '{16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0};
      vecs[6]  = '{16'd5,    16'd0,    16'hFFFF, 16'h0005, 1'b1, 1'b0};
      vecs[7]  = '{16'hFFFB, 16'd0,    16'hFFFF, 16'hFFFB, 1'b1, 1'b0};
      vecs[8]  = '{16'h7FFF, 16'd3,    16'h2AAA, 16'h0001, 1'b0, 1'b0};
      vecs[9]  = '{16'd3,    16'd10,   16'h0000, 16'h0003, 1'b0, 1'b0};
      vecs[10] = '{16'h8000, 16'd2,    16'hC000, 16'h0000, 1'b0, 1'b0};
      vecs[11] = '{16'h8000, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0};
      vecs[12] = '{16'd0,    16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0};
      vecs[13] = '{16'h1234, 16'h8000, 16'h0000, 16'h1234, 1'b0, 1'b0};
      vecs[14] = '{16'd7,    16'd2,    16'h0003, 16'h0001, 1'b0, 1'b0};

      ap_rst        = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.din0      = '0;
      bus.din1      = '0;
      repeat (3) @(posedge ap_clk);
      #1;
      chk("rst in_ready", 16'(bus.in_ready), 16'd1);
      chk("rst out_valid", 16'(bus.out_valid), 16'd0);
      chk("rst quot", bus.quot, 16'd0);
      chk("rst rem", bus.rem, 16'd0);
      chk("rst dbz", 16'(bus.dbz), 16'd0);
      chk("rst ovf", 16'(bus.ovf), 16'd0);
      ap_rst = 1'b0;
      @(negedge ap_clk);

      for (int i = 0; i < NV; i++) begin
         run_vec(i, vecs[i]);
      end

      // Back-pressure: result held, no accept in DONE, stray in_valid ignored
      start_op(16'd100, 16'd7);
      wait_result(lat);
      chk("stall latency", 16'(lat), 16'd17);
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin
            bus.din0     = 16'd9;
            bus.din1     = 16'd3;
            bus.in_valid = 1'b1;
         end
         @(posedge ap_clk);
         #1;
         bus.in_valid = 1'b0;
         chk($sformatf("stall%0d out_valid", k), 16'(bus.out_valid), 16'd1);
         chk($sformatf("stall%0d in_ready", k), 16'(bus.in_ready), 16'd0);
         chk($sformatf("stall%0d quot", k), bus.quot, 16'h000E);
         chk($sformatf("stall%0d rem", k), bus.rem, 16'h0002);
      end
      release_result("stall");
      repeat (20) @(posedge ap_clk);
      #1;
      chk("stall no_capture out_valid", 16'(bus.out_valid), 16'd0);
      chk("stall no_capture in_ready", 16'(bus.in_ready), 16'd1);
      chk("idle hold quot", bus.quot, 16'h000E);
      chk("idle hold rem", bus.rem, 16'h0002);

      // Reset during CALC (edge T+8): back to reset values, no partial result later
      start_op(16'd1000, 16'd3);
      repeat (7) @(posedge ap_clk);
      #1;
      ap_rst = 1'b1;
      @(posedge ap_clk);
      #1;
      ap_rst = 1'b0;
      chk("midrst out_valid", 16'(bus.out_valid), 16'd0);
      chk("midrst in_ready", 16'(bus.in_ready), 16'd1);
      chk("midrst quot", bus.quot, 16'd0);
      chk("midrst rem", bus.rem, 16'd0);
      repeat (25) @(posedge ap_clk);
      #1;
      chk("midrst no_result", 16'(bus.out_valid), 16'd0);
      start_op(16'd7, 16'd2);
      wait_result(lat);
      chk("postrst latency", 16'(lat), 16'd17);
      chk("postrst quot", bus.quot, 16'd3);
      chk("postrst rem", bus.rem, 16'd1);
      release_result("postrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
